// File: rtl/st7735_spi_sink_pkg.sv
// ---------------------------------------------------------------------------
// st7735_pkg
//   Shared definitions for the ST7735 write-stream sink: the command codes the
//   decoder reacts to and the encoding of the command/pixel FSM states.
// ---------------------------------------------------------------------------
package st7735_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CASET = 3'd1,
        S_RASET = 3'd2,
        S_RAMWR = 3'd3,
        S_SKIP  = 3'd4
    } state_e;

endpackage

// File: rtl/st7735_spi_sink_rx.sv
// ---------------------------------------------------------------------------
// spi_byte_rx
//   Oversampled SPI mode-0 byte receiver. All four pins go through 2-flop
//   synchronizers so they stay aligned; a byte completes on the 8th rising
//   sclk edge seen while cs is low. cs high drops any partial byte.
// Ports
//   clk, reset       system clock, async active-high reset
//   spi_cs/sclk/mosi/dc  raw asynchronous pins
//   byte_valid       1-cycle pulse, byte complete
//   byte_data        received byte, MSB first
//   byte_dc          dc level sampled together with the 8th bit
// ---------------------------------------------------------------------------
module spi_byte_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [1:0] cs_sync_q,   cs_sync_d;
    logic [1:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [1:0] dc_sync_q,   dc_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_q,      byte_d;
    logic       byte_dc_q,   byte_dc_d;

    logic       sclk_rise;
    logic [7:0] shift_next;

    always_comb begin
        cs_sync_d    = {cs_sync_q[0],   spi_cs};
        sclk_sync_d  = {sclk_sync_q[0], spi_sclk};
        mosi_sync_d  = {mosi_sync_q[0], spi_mosi};
        dc_sync_d    = {dc_sync_q[0],   spi_dc};
        sclk_prev_d  = sclk_sync_q[1];
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;

        sclk_rise  = sclk_sync_q[1] & ~sclk_prev_q & ~cs_sync_q[1];
        shift_next = {shift_q[6:0], mosi_sync_q[1]};

        if (cs_sync_q[1]) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = shift_next;
                byte_dc_d    = dc_sync_q[1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q    <= '0;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            dc_sync_q    <= '0;
            sclk_prev_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            byte_dc_q    <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            dc_sync_q    <= dc_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_q;
    assign byte_dc    = byte_dc_q;

endmodule

// File: rtl/st7735_spi_sink.sv
// ---------------------------------------------------------------------------
// st7735_spi_sink
//   Panel-side decoder for the 4-wire ST7735 write stream. Decodes command and
//   data bytes, tracks the CASET/RASET window and turns RAMWR data into
//   (x, y, RGB565) pixel writes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no active command, data bytes ignored
//   S_CASET | collecting 4 column-window argument bytes
//   S_RASET | collecting 4 row-window argument bytes
//   S_RAMWR | pairing data bytes into pixels, advancing the pointer
//   S_SKIP  | unsupported command, data bytes ignored
//
// Ports
//   clk, reset                   system clock, async active-high reset
//   spi_cs/sclk/mosi/dc          raw SPI pins (async)
//   cmd_valid, cmd_code          command pulse and last command byte (held)
//   pix_valid, pix_x/y, color    pixel pulse and its coordinates/colour (held)
//   frame_done                   pulses with the pixel at the window end
// ---------------------------------------------------------------------------
module st7735_spi_sink #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int H_PIXELS = 160,
    parameter int V_PIXELS = 80
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spi_cs,
    input  logic           spi_sclk,
    input  logic           spi_mosi,
    input  logic           spi_dc,
    output logic           cmd_valid,
    output logic [7:0]     cmd_code,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [15:0]    pix_color,
    output logic           frame_done
);

    import st7735_pkg::*;

    localparam logic [X_W-1:0] XE_DEF = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] YE_DEF = Y_W'(V_PIXELS - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_dc;

    spi_byte_rx u_rx (
        .clk        (clk),
        .reset      (reset),
        .spi_cs     (spi_cs),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .byte_dc    (rx_dc)
    );

    state_e         state_q,       state_d;
    logic [1:0]     arg_idx_q,     arg_idx_d;
    logic [7:0]     arg_lo_q,      arg_lo_d;
    logic [X_W-1:0] xs_q,          xs_d;
    logic [X_W-1:0] xe_q,          xe_d;
    logic [Y_W-1:0] ys_q,          ys_d;
    logic [Y_W-1:0] ye_q,          ye_d;
    logic [X_W-1:0] x_q,           x_d;
    logic [Y_W-1:0] y_q,           y_d;
    logic [7:0]     half_q,        half_d;
    logic           half_valid_q,  half_valid_d;
    logic           cmd_valid_q,   cmd_valid_d;
    logic [7:0]     cmd_code_q,    cmd_code_d;
    logic           pix_valid_q,   pix_valid_d;
    logic [X_W-1:0] pix_x_q,       pix_x_d;
    logic [Y_W-1:0] pix_y_q,       pix_y_d;
    logic [15:0]    pix_color_q,   pix_color_d;
    logic           frame_done_q,  frame_done_d;

    logic [X_W-1:0] col_s, col_e;
    logic [Y_W-1:0] row_s, row_e;

    always_comb begin
        state_d      = state_q;
        arg_idx_d    = arg_idx_q;
        arg_lo_d     = arg_lo_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        half_d       = half_q;
        half_valid_d = half_valid_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_color_d  = pix_color_q;
        frame_done_d = 1'b0;

        // Window start comes from the stored SL byte, end from the EL byte
        // arriving now; high bytes are never stored.
        col_s = arg_lo_q[X_W-1:0];
        col_e = rx_byte[X_W-1:0];
        row_s = arg_lo_q[Y_W-1:0];
        row_e = rx_byte[Y_W-1:0];

        if (rx_valid) begin
            if (!rx_dc) begin
                cmd_valid_d  = 1'b1;
                cmd_code_d   = rx_byte;
                half_valid_d = 1'b0;
                arg_idx_d    = 2'd0;
                case (rx_byte)
                    CMD_CASET: state_d = S_CASET;
                    CMD_RASET: state_d = S_RASET;
                    CMD_RAMWR: begin
                        state_d = S_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    CMD_SWRESET: begin
                        state_d = S_IDLE;
                        xs_d    = '0;
                        xe_d    = XE_DEF;
                        ys_d    = '0;
                        ye_d    = YE_DEF;
                    end
                    default: state_d = S_SKIP;
                endcase
            end else begin
                case (state_q)
                    S_CASET, S_RASET: begin
                        arg_idx_d = arg_idx_q + 2'd1;
                        if (arg_idx_q == 2'd1) begin
                            arg_lo_d = rx_byte;
                        end
                        if (arg_idx_q == 2'd3) begin
                            state_d   = S_IDLE;
                            arg_idx_d = 2'd0;
                            if (state_q == S_CASET) begin
                                xs_d = col_s;
                                xe_d = (col_s > col_e) ? col_s : col_e;
                            end else begin
                                ys_d = row_s;
                                ye_d = (row_s > row_e) ? row_s : row_e;
                            end
                        end
                    end
                    S_RAMWR: begin
                        if (!half_valid_q) begin
                            half_d       = rx_byte;
                            half_valid_d = 1'b1;
                        end else begin
                            half_valid_d = 1'b0;
                            pix_valid_d  = 1'b1;
                            pix_x_d      = x_q;
                            pix_y_d      = y_q;
                            pix_color_d  = {half_q, rx_byte};
                            if (x_q != xe_q) begin
                                x_d = x_q + X_W'(1);
                            end else if (y_q != ye_q) begin
                                x_d = xs_q;
                                y_d = y_q + Y_W'(1);
                            end else begin
                                frame_done_d = 1'b1;
                                x_d          = xs_q;
                                y_d          = ys_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            arg_idx_q    <= '0;
            arg_lo_q     <= '0;
            xs_q         <= '0;
            xe_q         <= XE_DEF;
            ys_q         <= '0;
            ye_q         <= YE_DEF;
            x_q          <= '0;
            y_q          <= '0;
            half_q       <= '0;
            half_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_color_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg_idx_q    <= arg_idx_d;
            arg_lo_q     <= arg_lo_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            half_q       <= half_d;
            half_valid_q <= half_valid_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_color_q  <= pix_color_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_color  = pix_color_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_st7735_spi_sink.sv
module tb_st7735_spi_sink;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    logic           clk = 1'b0;
    logic           reset;
    logic           spi_cs, spi_sclk, spi_mosi, spi_dc;
    logic           cmd_valid;
    logic [7:0]     cmd_code;
    logic           pix_valid;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [15:0]    pix_color;
    logic           frame_done;

    st7735_spi_sink #(.X_W(X_W), .Y_W(Y_W), .H_PIXELS(160), .V_PIXELS(80)) dut (
        .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_dc(spi_dc), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // events observed while the last byte was shifted in
    int ev_cnt, ev_kind, ev_lat, ev_code, ev_x, ev_y, ev_col, ev_fd;

    task automatic send_bits(input bit dc, input logic [7:0] v, input int n);
        ev_cnt = 0; ev_kind = 0; ev_lat = 0; ev_code = 0;
        ev_x = 0; ev_y = 0; ev_col = 0; ev_fd = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            spi_mosi = v[7-j];
            spi_dc   = dc;
            repeat (2) @(negedge clk);
            spi_sclk = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if (cmd_valid || pix_valid) begin
                    ev_cnt++;
                    ev_kind = (cmd_valid ? 1 : 0) + (pix_valid ? 2 : 0);
                    ev_lat  = (j == 7) ? k : 100 + 8 * j + k;
                    ev_code = cmd_code;
                    ev_x    = pix_x;
                    ev_y    = pix_y;
                    ev_col  = pix_color;
                    ev_fd   = frame_done;
                end
                if (k == 4) begin
                    @(negedge clk);
                    spi_sclk = 1'b0;
                end
            end
        end
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] v);
        send_bits(dc, v, 8);
    endtask

    task automatic cs_pulse();
        @(negedge clk); spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_none(input string n);
        chk({n, " events"}, ev_cnt, 0);
    endtask

    task automatic expect_cmd(input string n, input logic [7:0] code);
        chk({n, " events"}, ev_cnt, 1);
        chk({n, " kind"}, ev_kind, 1);
        chk({n, " latency"}, ev_lat, 4);
        chk({n, " cmd_code"}, ev_code, code);
    endtask

    task automatic expect_pix(input string n, input int x, input int y, input int col, input int fd);
        chk({n, " events"}, ev_cnt, 1);
        chk({n, " kind"}, ev_kind, 2);
        chk({n, " latency"}, ev_lat, 4);
        chk({n, " x"}, ev_x, x);
        chk({n, " y"}, ev_y, y);
        chk({n, " color"}, ev_col, col);
        chk({n, " frame_done"}, ev_fd, fd);
    endtask

    task automatic check_outputs_zero(input string n);
        chk({n, " cmd_valid"}, cmd_valid, 0);
        chk({n, " cmd_code"}, cmd_code, 0);
        chk({n, " pix_valid"}, pix_valid, 0);
        chk({n, " pix_x"}, pix_x, 0);
        chk({n, " pix_y"}, pix_y, 0);
        chk({n, " pix_color"}, pix_color, 0);
        chk({n, " frame_done"}, frame_done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        spi_cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- behavioural panel model (byte level) ----------------
    // mode: 0 idle, 1 column args, 2 row args, 3 memory write, 4 ignore
    int m_mode, m_args[$], m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_half;

    task automatic model_reset();
        m_mode = 0; m_args.delete();
        m_xs = 0; m_xe = 159; m_ys = 0; m_ye = 79;
        m_x = 0; m_y = 0; m_half = -1;
    endtask

    task automatic model_byte(input bit dc, input int v, output int kind, output int code,
                              output int x, output int y, output int col, output int fd);
        kind = 0; code = 0; x = 0; y = 0; col = 0; fd = 0;
        if (!dc) begin
            kind = 1; code = v; m_half = -1; m_args.delete();
            if (v == 'h2A) m_mode = 1;
            else if (v == 'h2B) m_mode = 2;
            else if (v == 'h2C) begin m_mode = 3; m_x = m_xs; m_y = m_ys; end
            else if (v == 'h01) begin
                m_mode = 0; m_xs = 0; m_xe = 159; m_ys = 0; m_ye = 79;
            end else m_mode = 4;
        end else if (m_mode == 1 || m_mode == 2) begin
            m_args.push_back(v);
            if (m_args.size() == 4) begin
                int s, e, lim;
                lim = (m_mode == 1) ? 256 : 128;
                s = m_args[1] % lim;
                e = m_args[3] % lim;
                if (e < s) e = s;
                if (m_mode == 1) begin m_xs = s; m_xe = e; end
                else begin m_ys = s; m_ye = e; end
                m_mode = 0;
                m_args.delete();
            end
        end else if (m_mode == 3) begin
            if (m_half < 0) m_half = v;
            else begin
                kind = 2; x = m_x; y = m_y; col = m_half * 256 + v; m_half = -1;
                if (m_x < m_xe) m_x++;
                else if (m_y < m_ye) begin m_x = m_xs; m_y++; end
                else begin fd = 1; m_x = m_xs; m_y = m_ys; end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         dc;
        logic [7:0] val;
        int         kind;   // 0 none, 1 command, 2 pixel
        int         code;
        int         x, y, col, fd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit dc, logic [7:0] val, int kind, int code,
                                int x, int y, int col, int fd);
        vec_t r;
        r.dc = dc; r.val = val; r.kind = kind; r.code = code;
        r.x = x; r.y = y; r.col = col; r.fd = fd;
        return r;
    endfunction

    initial begin
        int mk_kind, mk_code, mk_x, mk_y, mk_col, mk_fd;
        string nm;

        tbl.push_back(mk(0, 8'h2C, 1, 'h2C, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hF8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 2, 0, 0, 0, 'hF800, 0));
        tbl.push_back(mk(1, 8'h07, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hE0, 2, 0, 1, 0, 'h07E0, 0));
        tbl.push_back(mk(0, 8'h2A, 1, 'h2A, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h06, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h2B, 1, 'h2B, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h2C, 1, 'h2C, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 2, 0, 5, 2, 'h1122, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h44, 2, 0, 6, 2, 'h3344, 0));
        tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h66, 2, 0, 5, 3, 'h5566, 0));
        tbl.push_back(mk(1, 8'h77, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h88, 2, 0, 6, 3, 'h7788, 1));
        tbl.push_back(mk(1, 8'h99, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 2, 0, 5, 2, 'h99AA, 0));

        reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        do_reset();

        // table: first pixels, then window + wrap
        for (int i = 0; i < tbl.size(); i++) begin
            nm = $sformatf("tbl[%0d]", i);
            send_byte(tbl[i].dc, tbl[i].val);
            if (tbl[i].kind == 0) expect_none(nm);
            else if (tbl[i].kind == 1) expect_cmd(nm, tbl[i].code[7:0]);
            else expect_pix(nm, tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].fd);
        end
        chk("held cmd_code", cmd_code, 'h2C);
        chk("held pix_color", pix_color, 'h99AA);

        // half pixel dropped by a command
        send_byte(0, 8'h2C); expect_cmd("drop.ramwr1", 8'h2C);
        send_byte(1, 8'hAA); expect_none("drop.aa");
        send_byte(0, 8'h00); expect_cmd("drop.nop", 8'h00);
        send_byte(0, 8'h2C); expect_cmd("drop.ramwr2", 8'h2C);
        send_byte(1, 8'h12); expect_none("drop.12");
        send_byte(1, 8'h34); expect_pix("drop.pix", 5, 2, 'h1234, 0);

        // cs abort mid-byte, then full CASET with start > end
        send_bits(0, 8'h2C, 3); expect_none("abort.partial");
        cs_pulse();
        send_byte(0, 8'h2A); expect_cmd("abort.caset", 8'h2A);
        send_byte(1, 8'h00); send_byte(1, 8'h0A);
        send_byte(1, 8'h00); send_byte(1, 8'h04); expect_none("caset.el");
        send_byte(0, 8'h2C); expect_cmd("narrow.ramwr", 8'h2C);
        send_byte(1, 8'h12);
        cs_pulse();
        send_byte(1, 8'h34); expect_pix("cs_between.pix", 10, 2, 'h1234, 0);
        send_byte(1, 8'h56);
        send_byte(1, 8'h78); expect_pix("narrow.pix2", 10, 3, 'h5678, 1);

        // SWRESET restores the full-panel window
        send_byte(0, 8'h01); expect_cmd("swreset", 8'h01);
        send_byte(0, 8'h2C); expect_cmd("swreset.ramwr", 8'h2C);
        for (int i = 0; i <= 160; i++) begin
            logic [15:0] c;
            c = 16'(i * 7 + 3);
            send_byte(1, c[15:8]);
            send_byte(1, c[7:0]);
            expect_pix($sformatf("full.pix%0d", i), i % 160, i / 160, c, 0);
        end

        // reset in the middle of a pixel and of a byte
        send_byte(0, 8'h2C); expect_cmd("rst.ramwr", 8'h2C);
        send_byte(1, 8'h11);
        send_bits(1, 8'hFF, 4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge clk);
        spi_sclk = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(0, 8'h2C); expect_cmd("post_rst.ramwr", 8'h2C);
        send_byte(1, 8'h56); expect_none("post_rst.hi");
        send_byte(1, 8'h78); expect_pix("post_rst.pix", 0, 0, 'h5678, 0);

        // randomized stream against the byte-level model
        do_reset();
        model_reset();
        for (int n = 0; n < 200; n++) begin
            int r, v;
            bit dc;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                send_bits($urandom_range(0, 1), 8'($urandom), $urandom_range(1, 7));
                expect_none($sformatf("rnd%0d.partial", n));
                cs_pulse();
            end else if (r < 9) begin
                cs_pulse();
            end
            if ($urandom_range(0, 99) < 18) begin
                dc = 0;
                case ($urandom_range(0, 6))
                    0: v = 'h2A;
                    1: v = 'h2B;
                    2, 3: v = 'h2C;
                    4: v = 'h01;
                    5: v = 'h00;
                    default: v = $urandom_range(0, 255);
                endcase
            end else begin
                dc = 1;
                if ((m_mode == 1 || m_mode == 2) && (m_args.size() % 2 == 1))
                    v = $urandom_range(0, 12) + ($urandom_range(0, 1) * 128);
                else
                    v = $urandom_range(0, 255);
            end
            model_byte(dc, v, mk_kind, mk_code, mk_x, mk_y, mk_col, mk_fd);
            send_byte(dc, 8'(v));
            nm = $sformatf("rnd%0d", n);
            if (mk_kind == 0) expect_none(nm);
            else if (mk_kind == 1) expect_cmd(nm, 8'(mk_code));
            else expect_pix(nm, mk_x, mk_y, mk_col, mk_fd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
